// File: rtl/knn_pkg.sv
// Shared definitions for the KNN classification controller: FSM state
// encoding, a constant-foldable clog2 and the default datapath sizes.
package knn_pkg;

    localparam int W_DEF      = 32;
    localparam int TYPE_W_DEF = 2;
    localparam int K_DEF      = 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_INSERT = 3'd3,
        S_VOTE   = 3'd4,
        S_DONE   = 3'd5
    } knn_state_t;

    // Smallest r with 2**r >= value (0 for value <= 1)
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/knn_topk_list.sv
// Sorted list of the K smallest distances seen so far, ascending.
// One insertion per cycle: every slot compares itself against the newcomer
// and either keeps its entry, takes the newcomer, or takes its left
// neighbour. Equal distances queue behind existing ones so earlier samples
// win ties. When full, a newcomer not strictly below the last entry is
// dropped.
module knn_topk_list
    import knn_pkg::*;
#(
    parameter int K      = K_DEF,
    parameter int W      = W_DEF,
    parameter int TYPE_W = TYPE_W_DEF,
    parameter int FILL_W = clog2(K + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clear,
    input  logic                      i_insert,
    input  logic [W-1:0]              i_dist,
    input  logic [TYPE_W-1:0]         i_type,
    output logic [K-1:0][W-1:0]       o_dist,
    output logic [K-1:0][TYPE_W-1:0]  o_type,
    output logic [FILL_W-1:0]         o_fill
);

    logic [K-1:0][W-1:0]      r_dist;
    logic [K-1:0][TYPE_W-1:0] r_type;
    logic [FILL_W-1:0]        r_fill;
    logic [K-1:0]             w_le;
    logic [K-1:0][W-1:0]      w_dist_nxt;
    logic [K-1:0][TYPE_W-1:0] w_type_nxt;

    // Valid entries that stay ahead of the newcomer (<= keeps older ties first)
    always_comb begin
        w_le = '0;
        for (int i = 0; i < K; i++) begin
            w_le[i] = (FILL_W'(i) < r_fill) && (r_dist[i] <= i_dist);
        end
    end

    // Per-slot select: keep own entry, take the newcomer, or shift right
    always_comb begin
        w_dist_nxt = r_dist;
        w_type_nxt = r_type;
        if (!w_le[0]) begin
            w_dist_nxt[0] = i_dist;
            w_type_nxt[0] = i_type;
        end
        for (int i = 1; i < K; i++) begin
            if (!w_le[i]) begin
                if (w_le[i-1]) begin
                    w_dist_nxt[i] = i_dist;
                    w_type_nxt[i] = i_type;
                end else begin
                    w_dist_nxt[i] = r_dist[i-1];
                    w_type_nxt[i] = r_type[i-1];
                end
            end
        end
    end

    // Occupancy count; saturates at K once the list is full
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fill <= '0;
        end else if (i_clear) begin
            r_fill <= '0;
        end else if (i_insert && (r_fill < FILL_W'(K))) begin
            r_fill <= r_fill + 1'b1;
        end
    end

    // Entry storage; contents beyond r_fill are never consulted
    always_ff @(posedge i_clk) begin
        if (i_insert) begin
            r_dist <= w_dist_nxt;
            r_type <= w_type_nxt;
        end
    end

    assign o_dist = r_dist;
    assign o_type = r_type;
    assign o_fill = r_fill;

endmodule

// File: rtl/knn_controller.sv
// KNN classification sequencer. Walks the training index, pulses the shared
// distance calculator once per sample, keeps the K nearest results in a
// knn_topk_list and majority-votes the predicted type (ties go to the type
// nearest the head of the list).
// Optional build macro KNN_CTRL_TIMEOUT_EN adds a WAIT watchdog that aborts
// the pass with error=1; without it WAIT is unbounded and error is 0.
module knn_controller
    import knn_pkg::*;
#(
    parameter int W              = 32,
    parameter int TYPE_W         = 2,
    parameter int MAX_ELEMENTS   = 30,
    parameter int K              = 3,
    parameter int IDX_W          = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W:0]    num_elements,
    output logic [IDX_W-1:0]  train_addr,
    output logic              calc_ready,
    input  logic              calc_done,
    input  logic [W-1:0]      calc_distance,
    input  logic [TYPE_W-1:0] calc_type,
    output logic              busy,
    output logic              done,
    output logic [TYPE_W-1:0] result_type,
    output logic [W-1:0]      min_distance,
    output logic              error
);

    localparam int FILL_W    = clog2(K + 1);
    localparam int CNT_W     = clog2(K + 1);
    localparam int NUM_TYPES = 1 << TYPE_W;
    localparam logic [IDX_W:0] MAX_N = (IDX_W + 1)'(MAX_ELEMENTS);

    knn_state_t               r_state;
    knn_state_t               w_next;
    logic [IDX_W:0]           r_n;
    logic [IDX_W-1:0]         r_idx;
    logic [W-1:0]             r_cap_dist;
    logic [TYPE_W-1:0]        r_cap_type;
    logic [TYPE_W-1:0]        r_result_type;
    logic [W-1:0]             r_min_distance;

    logic [IDX_W:0]           w_n_start;
    logic [IDX_W:0]           w_idx_inc;
    logic                     w_more;
    logic                     w_clear;
    logic                     w_insert;
    logic                     w_wd_expire;
    logic [K-1:0][W-1:0]      w_list_dist;
    logic [K-1:0][TYPE_W-1:0] w_list_type;
    logic [FILL_W-1:0]        w_fill;
    logic [CNT_W-1:0]         w_cnt [NUM_TYPES];
    logic [CNT_W-1:0]         w_best_cnt;
    logic [TYPE_W-1:0]        w_vote_type;
    logic [W-1:0]             w_vote_min;

    assign w_n_start = (num_elements > MAX_N) ? MAX_N : num_elements;
    assign w_idx_inc = {1'b0, r_idx} + 1'b1;
    assign w_more    = (w_idx_inc < r_n);

    knn_topk_list #(
        .K      (K),
        .W      (W),
        .TYPE_W (TYPE_W),
        .FILL_W (FILL_W)
    ) u_topk (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_clear  (w_clear),
        .i_insert (w_insert),
        .i_dist   (r_cap_dist),
        .i_type   (r_cap_type),
        .o_dist   (w_list_dist),
        .o_type   (w_list_type),
        .o_fill   (w_fill)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and list strobes
    always_comb begin
        w_next   = r_state;
        w_clear  = 1'b0;
        w_insert = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clear = 1'b1;
                    w_next  = (w_n_start == '0) ? S_VOTE : S_ISSUE;
                end
            end
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT: begin
                if (calc_done) begin
                    w_next = S_INSERT;
                end else if (w_wd_expire) begin
                    w_next = S_DONE;
                end
            end
            S_INSERT: begin
                w_insert = 1'b1;
                w_next   = w_more ? S_ISSUE : S_VOTE;
            end
            S_VOTE:   w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Sample index and pass length, latched on an accepted start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_n   <= '0;
            r_idx <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_n   <= w_n_start;
            r_idx <= '0;
        end else if ((r_state == S_INSERT) && w_more) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    // Capture the calculator result; only a response seen in WAIT counts
    always_ff @(posedge clk) begin
        if ((r_state == S_WAIT) && calc_done) begin
            r_cap_dist <= calc_distance;
            r_cap_type <= calc_type;
        end
    end

    // Majority vote over the occupied list; ties resolve to the nearest slot
    always_comb begin
        for (int t = 0; t < NUM_TYPES; t++) begin
            w_cnt[t] = '0;
        end
        for (int j = 0; j < K; j++) begin
            if (FILL_W'(j) < w_fill) begin
                w_cnt[w_list_type[j]] = w_cnt[w_list_type[j]] + 1'b1;
            end
        end
        w_best_cnt  = '0;
        w_vote_type = '0;
        for (int j = 0; j < K; j++) begin
            if ((FILL_W'(j) < w_fill) && (w_cnt[w_list_type[j]] > w_best_cnt)) begin
                w_best_cnt  = w_cnt[w_list_type[j]];
                w_vote_type = w_list_type[j];
            end
        end
        w_vote_min = (w_fill == '0) ? '1 : w_list_dist[0];
    end

    // Publish the vote on the edge that enters DONE, then hold it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_result_type  <= '0;
            r_min_distance <= '0;
        end else if (w_next == S_DONE) begin
            r_result_type  <= w_vote_type;
            r_min_distance <= w_vote_min;
        end
    end

`ifdef KNN_CTRL_TIMEOUT_EN
    localparam int WD_W = clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_error;

    // Watchdog: consecutive cycles spent in WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign w_wd_expire = (r_state == S_WAIT) && !calc_done &&
                         (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Abort flag: raised with the timed-out DONE, cleared by the next start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_error <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_error <= 1'b0;
        end else if (w_wd_expire) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign w_wd_expire = 1'b0;
    assign error       = 1'b0;
`endif

    assign train_addr   = r_idx;
    assign calc_ready   = (r_state == S_ISSUE);
    assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done         = (r_state == S_DONE);
    assign result_type  = r_result_type;
    assign min_distance = r_min_distance;

endmodule

// File: tb/tb_knn_controller.sv
// Self-checking bench for knn_controller: a responder plays the distance
// calculator from a sample memory, a reference model picks the K nearest by
// repeated minimum search and votes, and a monitor compares every cycle.
module tb_knn_controller;

    localparam int W      = 32;
    localparam int TYPE_W = 2;
    localparam int MAX_E  = 30;
    localparam int K      = 3;
    localparam int IDX_W  = 5;
    localparam int TMO    = 1024;
    localparam int LAT    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [IDX_W:0]    num_elements = '0;
    logic [IDX_W-1:0]  train_addr;
    logic              calc_ready;
    logic              calc_done;
    logic [W-1:0]      calc_distance;
    logic [TYPE_W-1:0] calc_type;
    logic              busy;
    logic              done;
    logic [TYPE_W-1:0] result_type;
    logic [W-1:0]      min_distance;
    logic              error;

    logic [W-1:0]      dist_mem [0:63];
    logic [TYPE_W-1:0] type_mem [0:63];

    int n_checks = 0;
    int n_fail   = 0;
    int pulse_cnt = 0;
    bit resp_off = 0;
    bit stray_en = 0;
    bit use_rand_lat = 0;
    bit hold_valid = 0;
    logic [TYPE_W-1:0] exp_type = '0;
    logic [W-1:0]      exp_min = '0;
    logic              exp_error = 1'b0;
    logic [TYPE_W-1:0] held_type = '0;
    logic [W-1:0]      held_min = '0;

    knn_controller #(
        .W(W), .TYPE_W(TYPE_W), .MAX_ELEMENTS(MAX_E), .K(K), .IDX_W(IDX_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_elements(num_elements),
        .train_addr(train_addr), .calc_ready(calc_ready), .calc_done(calc_done),
        .calc_distance(calc_distance), .calc_type(calc_type), .busy(busy), .done(done),
        .result_type(result_type), .min_distance(min_distance), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: K nearest by repeated minimum search (lowest index wins ties),
    // then majority vote with ties going to the type seen nearest the head.
    task automatic model(input int n);
        logic [W-1:0]      pd [K];
        logic [TYPE_W-1:0] pt [K];
        bit used [64];
        int fill, best, maxc;
        int cnt [4];
        for (int i = 0; i < 64; i++) used[i] = 0;
        for (int t = 0; t < 4; t++) cnt[t] = 0;
        fill = (n < K) ? n : K;
        for (int s = 0; s < fill; s++) begin
            best = -1;
            for (int i = 0; i < n; i++)
                if (!used[i] && (best < 0 || dist_mem[i] < dist_mem[best])) best = i;
            used[best] = 1;
            pd[s] = dist_mem[best];
            pt[s] = type_mem[best];
        end
        exp_min = (fill == 0) ? '1 : pd[0];
        for (int s = 0; s < fill; s++) cnt[pt[s]]++;
        maxc = 0;
        for (int t = 0; t < 4; t++) if (cnt[t] > maxc) maxc = cnt[t];
        exp_type = '0;
        for (int s = fill - 1; s >= 0; s--) if (cnt[pt[s]] == maxc) exp_type = pt[s];
    endtask

    // Calculator stand-in: answers each calc_ready after a latency, optionally
    // preceded by a stray calc_done during the ISSUE cycle.
    initial begin : responder
        int a, lat;
        calc_done = 1'b0;
        calc_distance = '0;
        calc_type = '0;
        forever begin
            @(negedge clk);
            if (rst && calc_ready && !resp_off) begin
                a = int'(train_addr);
                lat = use_rand_lat ? int'($urandom_range(1, 6)) : LAT;
                if (stray_en) begin
                    calc_done = 1'b1;
                    calc_distance = '0;
                    calc_type = 2'd3;
                end
                @(posedge clk);
                #1 calc_done = 1'b0;
                repeat (lat - 1) @(posedge clk);
                #1;
                calc_done = 1'b1;
                calc_distance = dist_mem[a];
                calc_type = type_mem[a];
                @(posedge clk);
                #1;
                calc_done = 1'b0;
                calc_distance = $urandom;
                calc_type = TYPE_W'($urandom);
            end
        end
    end

    // Per-cycle compare process
    initial begin : monitor
        logic prev_ready;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                hold_valid = 0;
                prev_ready = 1'b0;
            end else begin
                if (calc_ready) begin
                    chk("ready_single_cycle", prev_ready, 0);
                    chk("train_addr", train_addr, pulse_cnt);
                    chk("busy_with_ready", busy, 1);
                    pulse_cnt++;
                end
                if (done) begin
                    chk("result_type", result_type, exp_type);
                    chk("min_distance", min_distance, exp_min);
                    chk("error", error, exp_error);
                    chk("busy_in_done", busy, 0);
                    held_type = exp_type;
                    held_min = exp_min;
                    hold_valid = 1;
                end else if (hold_valid) begin
                    chk("hold_result_type", result_type, held_type);
                    chk("hold_min_distance", min_distance, held_min);
                end
                prev_ready = calc_ready;
            end
        end
    end

    initial begin : global_guard
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic fill_random();
        for (int i = 0; i < 64; i++) begin
            dist_mem[i] = ($urandom_range(0, 3) == 0) ? $urandom : W'($urandom_range(0, 15));
            type_mem[i] = TYPE_W'($urandom_range(0, 3));
        end
    endtask

    task automatic start_pass(input int num);
        @(posedge clk);
        #1;
        start = 1'b1;
        num_elements = (IDX_W + 1)'(num);
        @(posedge clk);
        #1;
        start = 1'b0;
        num_elements = (IDX_W + 1)'($urandom);
    endtask

    task automatic run_pass(input int num, input bit rnd_lat, input bit mid);
        int n_eff, cyc;
        n_eff = (num > MAX_E) ? MAX_E : num;
        model(n_eff);
        use_rand_lat = rnd_lat;
        pulse_cnt = 0;
        start_pass(num);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mid && cyc == 9) begin
                start = 1'b1;
                num_elements = 6'd3;
            end
            if (mid && cyc == 10) start = 1'b0;
        end while (!done && cyc < 4000);
        start = 1'b0;
        chk("done_seen", done, 1);
        if (!rnd_lat) chk("done_latency", cyc, n_eff * (LAT + 2) + 2);
        chk("ready_pulses", pulse_cnt, n_eff);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin : main
        int cyc;
        bit seen;
        for (int i = 0; i < 64; i++) begin
            dist_mem[i] = '0;
            type_mem[i] = '0;
        end
        // Reset state
        #12;
        chk("rst_calc_ready", calc_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_train_addr", train_addr, 0);
        chk("rst_result_type", result_type, 0);
        chk("rst_min_distance", min_distance, 0);
        chk("rst_error", error, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Worked example: ties in distance and in vote
        dist_mem[0] = 40; dist_mem[1] = 10; dist_mem[2] = 30; dist_mem[3] = 10; dist_mem[4] = 50;
        type_mem[0] = 1;  type_mem[1] = 2;  type_mem[2] = 1;  type_mem[3] = 3;  type_mem[4] = 0;
        run_pass(5, 0, 0);
        chk("pin_ex1_type", exp_type, 2);
        chk("pin_ex1_min", exp_min, 10);

        // Empty pass
        run_pass(0, 0, 0);
        chk("pin_empty_type", exp_type, 0);
        chk("pin_empty_min", exp_min, 32'hFFFF_FFFF);

        // Partially filled list
        dist_mem[0] = 7; dist_mem[1] = 9; type_mem[0] = 3; type_mem[1] = 3;
        run_pass(2, 0, 0);
        chk("pin_two_type", exp_type, 3);

        // Oversized request is clamped to MAX_ELEMENTS
        fill_random();
        run_pass(40, 0, 0);
        chk("pulses_clamped", pulse_cnt, 30);

        // Start while busy and stray calc_done in ISSUE are ignored
        fill_random();
        stray_en = 1;
        run_pass(6, 0, 1);
        stray_en = 0;

        // Reset while waiting on the calculator
        resp_off = 1;
        pulse_cnt = 0;
        start_pass(3);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_calc_ready", calc_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_train_addr", train_addr, 0);
        chk("midrst_result_type", result_type, 0);
        chk("midrst_min_distance", min_distance, 0);
        chk("midrst_error", error, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("midrst_no_done", seen, 0);
        resp_off = 0;

        // Randomized passes
        for (int p = 0; p < 10; p++) begin
            int num;
            bit rl, mid;
            fill_random();
            num = $urandom_range(0, 40);
            rl = 1'($urandom_range(0, 1));
            mid = (num >= 5) && ($urandom_range(0, 1) == 1);
            stray_en = 1'($urandom_range(0, 1));
            run_pass(num, rl, mid);
        end
        stray_en = 0;

`ifdef KNN_CTRL_TIMEOUT_EN
        // Calculator never answers: watchdog closes the pass with error
        resp_off = 1;
        model(0);
        exp_error = 1'b1;
        pulse_cnt = 0;
        start_pass(4);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 3000);
        chk("timeout_done_seen", done, 1);
        chk("timeout_latency", cyc, TMO + 2);
        @(negedge clk);
        resp_off = 0;
        exp_error = 1'b0;
        fill_random();
        run_pass(4, 0, 0);
`else
        cyc = 0;
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/knn_controller.md
# knn_controller

Sequencer for a K-nearest-neighbour classification pass. On `start` it steps a training-sample index through the stored set and pulses the distance calculator once per sample. It collects each returned distance/type pair into a sorted list of the K smallest distances, then takes a majority vote over that list to produce the predicted type. It sits between the top-level control interface and a single shared distance calculator instance.

## Interface
- `W`, 32, distance word width (matches the calculator)
- `TYPE_W`, 2, training-type code width
- `MAX_ELEMENTS`, 30, maximum number of training samples
- `K`, 3, neighbours kept and voted (1 ≤ K ≤ MAX_ELEMENTS)
- `IDX_W`, 5, index width, ≥ clog2(MAX_ELEMENTS)
- `TIMEOUT_CYCLES`, 1024, watchdog limit (used only with the macro)

Ports:
- `clk  in  1` — clock, rising edge
- `rst  in  1` — asynchronous, active-low reset
- `start  in  1` — begin a pass; sampled only in IDLE
- `num_elements  in  IDX_W+1` — training samples to scan; sampled with `start`
- `train_addr  out  IDX_W` — index of the sample presented to the calculator
- `calc_ready  out  1` — one-cycle start pulse to the calculator
- `calc_done  in  1` — calculator result valid
- `calc_distance  in  W` — calculator distance
- `calc_type  in  TYPE_W` — type code of the current sample
- `busy  out  1` — high from the cycle after `start` until `done`
- `done  out  1` — one-cycle completion pulse
- `result_type  out  TYPE_W` — voted type; held until the next `done`
- `min_distance  out  W` — smallest distance seen; held until the next `done`
- `error  out  1` — last pass aborted (timeout build only, else tied 0)

## Operation
- States:
  - IDLE → ISSUE when `start`=1.
  - ISSUE → WAIT, always.
  - WAIT → INSERT on `calc_done`.
  - INSERT → ISSUE if `idx+1 < n`, else → VOTE.
  - VOTE → DONE.
  - DONE → IDLE.
- On `start`, latch `n = min(num_elements, MAX_ELEMENTS)`, set `idx=0`, and clear the list (`fill=0`).
- If `n=0`, go straight to VOTE. The pass yields `result_type=0` and `min_distance` all-ones.
- ISSUE: `calc_ready`=1 for exactly one cycle. `train_addr=idx`, held stable through WAIT.
- WAIT: `calc_distance` and `calc_type` are captured in the cycle `calc_done`=1. `calc_done` is ignored in every other state.
- INSERT: the list is sorted ascending by distance; insertion takes one cycle.
  - If `fill<K`, insert in sorted position and increment `fill`.
  - Else, if distance < `list[K-1]`, insert and drop the last entry.
  - Else, discard the sample.
  - Ties: an equal distance goes after existing equal entries, so the earlier index wins.
- VOTE: count each type over `list[0..fill-1]` using 2^TYPE_W counters of width clog2(K+1).
  - `result_type` = type with the highest count.
  - Count tie → the tied type that owns the lowest list position, i.e. the nearest.
  - `min_distance = list[0]`.
- `start` while `busy` is ignored.
- Distances are unsigned W-bit; comparisons are unsigned. There is no arithmetic on distances.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE
  - `calc_ready`=0, `busy`=0, `done`=0
  - `train_addr`=0, `result_type`=0, `min_distance`=0, `error`=0
  - `fill`=0
- `start` sampled at edge t0 → ISSUE at t0+1 (`calc_ready` high, `busy` high).
- Per-sample cost = calculator latency L + 2 cycles (ISSUE + INSERT). L counts from the `calc_ready` edge to the `calc_done` edge.
- Last INSERT at edge t → VOTE at t+1 → DONE at t+2.
  - In DONE: `done`=1 and `busy`=0.
  - `result_type`, `min_distance` and `error` update at that same edge.
- `calc_done` arriving in the same cycle as `calc_ready`: WAIT is entered on the next edge, so this is treated as a response to a prior pulse and ignored.
- Reset mid-pass aborts immediately. Outputs return to reset values and no `done` is generated.

## Configuration
- `KNN_CTRL_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - After TIMEOUT_CYCLES without `calc_done`, go to DONE with `error`=1 and `result_type`/`min_distance` reflecting the partial list.
  - `error` clears at the next `start`.
- Undefined: WAIT is unbounded and `error` is constant 0.

## Structure
- Shared package `knn_pkg`: state enum, `clog2` function, default K/TYPE_W/W constants.
- Sub-module `knn_topk_list`:
  - parameters K, W, TYPE_W
  - inputs: clear, insert strobe, distance, type
  - outputs: sorted entries, `fill`
  - holds the one-cycle compare-and-shift insertion
- The controller holds the FSM, the index counter, the vote logic and the watchdog.

## Test plan
- Scan with n=5, K=3, fixed-latency calculator model (L=4).
  - Distances 40,10,30,10,50 with types 1,2,1,3,0 → list {10(t2),10(t3),30(t1)}.
  - Tied vote (2, 3 and 1 each once) → `result_type`=2, `min_distance`=10, `done` 1 cycle.
- `num_elements`=0 → `done` 3 cycles after `start`; `result_type`=0, `min_distance`=all-ones; `calc_ready` never asserted.
- `num_elements`=40 → exactly 30 `calc_ready` pulses, with `train_addr` running 0..29 in order.
- n=2, K=3, types 3,3 → vote over 2 entries, `result_type`=3.
- `start` pulsed mid-pass and stray `calc_done` in ISSUE → no effect.
- Reset asserted during WAIT → all outputs at reset values the same cycle, no `done`.
- Timeout build:
  - `calc_done` withheld → `error`=1 with `done` after TIMEOUT_CYCLES.
  - The next clean pass clears `error`.
